// File: rtl/dds_sweep_ctrl.sv
// DDS frequency-sweep sequencer: programs each phase increment, lets the
// FIR settle, then reports the peak |sample| seen in the capture window.
module dds_sweep_ctrl #(
    parameter int PINC_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SETTLE  = 64,
    parameter int CAPTURE = 256
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic [PINC_W-1:0] pinc_start,
    input  logic [PINC_W-1:0] pinc_step,
    input  logic [15:0]       num_steps,
    output logic              m_axis_config_tvalid,
    input  logic              m_axis_config_tready,
    output logic [PINC_W-1:0] m_axis_config_tdata,
    input  logic              s_axis_data_tvalid,
    input  logic [DATA_W-1:0] s_axis_data_tdata,
    output logic              busy,
    output logic              res_valid,
    output logic [15:0]       res_step,
    output logic [DATA_W-1:0] res_peak,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_SETTLE,
        S_CAPTURE,
        S_REPORT
    } state_t;

    localparam int MAXC  = (SETTLE > CAPTURE) ? SETTLE : CAPTURE;
    localparam int CNT_W = $clog2(MAXC + 1);

    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CAP_LAST = CNT_W'(CAPTURE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [DATA_W-1:0] MAG_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    state_t            state_q, state_d;
    logic [PINC_W-1:0] pinc_q, pinc_d;
    logic [PINC_W-1:0] step_q, step_d;
    logic [15:0]       nsteps_q, nsteps_d;
    logic [15:0]       idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] peak_q, peak_d;
    logic [15:0]       res_step_q, res_step_d;
    logic [DATA_W-1:0] res_peak_q, res_peak_d;
    logic              zdone_q, zdone_d;

    logic [DATA_W-1:0] mag;
    logic [DATA_W-1:0] peak_nx;
    logic              last_step;

    assign last_step = (idx_q == nsteps_q - 16'd1);

    // Most-negative input has no positive twin; clamp it to full scale.
    always_comb begin
        mag = s_axis_data_tdata;
        if (s_axis_data_tdata == MIN_NEG) begin
            mag = MAG_MAX;
        end else if (s_axis_data_tdata[DATA_W-1]) begin
            mag = -s_axis_data_tdata;
        end
        peak_nx = (mag > peak_q) ? mag : peak_q;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            pinc_q     <= '0;
            step_q     <= '0;
            nsteps_q   <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            peak_q     <= '0;
            res_step_q <= '0;
            res_peak_q <= '0;
            zdone_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pinc_q     <= pinc_d;
            step_q     <= step_d;
            nsteps_q   <= nsteps_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            peak_q     <= peak_d;
            res_step_q <= res_step_d;
            res_peak_q <= res_peak_d;
            zdone_q    <= zdone_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && (num_steps != 16'd0)) state_d = S_CFG;
            end
            S_CFG: begin
                if (m_axis_config_tready) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (s_axis_data_tvalid && (cnt_q == SET_LAST)) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (s_axis_data_tvalid && (cnt_q == CAP_LAST)) begin
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                state_d = last_step ? S_IDLE : S_CFG;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pinc_d     = pinc_q;
        step_d     = step_q;
        nsteps_d   = nsteps_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        peak_d     = peak_q;
        res_step_d = res_step_q;
        res_peak_d = res_peak_q;
        zdone_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start && (num_steps == 16'd0)) begin
                    zdone_d = 1'b1;
                end else if (start) begin
                    pinc_d   = pinc_start;
                    step_d   = pinc_step;
                    nsteps_d = num_steps;
                    idx_d    = 16'd0;
                end
            end
            S_CFG: begin
                if (m_axis_config_tready) cnt_d = '0;
            end
            S_SETTLE: begin
                if (s_axis_data_tvalid) begin
                    if (cnt_q == SET_LAST) begin
                        cnt_d  = '0;
                        peak_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            S_CAPTURE: begin
                if (s_axis_data_tvalid) begin
                    peak_d = peak_nx;
                    cnt_d  = cnt_q + CNT_ONE;
                    if (cnt_q == CAP_LAST) begin
                        cnt_d      = '0;
                        res_step_d = idx_q;
                        res_peak_d = peak_nx;
                    end
                end
            end
            S_REPORT: begin
                if (!last_step) begin
                    idx_d  = idx_q + 16'd1;
                    pinc_d = pinc_q + step_q;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy                 = (state_q != S_IDLE);
        m_axis_config_tvalid = (state_q == S_CFG);
        m_axis_config_tdata  = pinc_q;
        res_valid            = (state_q == S_REPORT);
        res_step             = res_step_q;
        res_peak             = res_peak_q;
        done = ((state_q == S_REPORT) && last_step) || zdone_q;
    end

endmodule
